// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode and Funct field constants
//   - ALUControl encodings and the FSM-to-decoder ALUOp codes
//   - ALUSrcB and PCSrc select encodings
//   - controller state enum (S_TRAP exists only with ILLEGAL_OP_TRAP_EN)
// Optional macro: ILLEGAL_OP_TRAP_EN adds the TRAP state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
`else
    S_JUMP    = 4'd11
`endif
  } state_e;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder for the multicycle controller.
//   alu_op     in  2  00 add, 01 sub, 10 decode Funct
//   funct      in  6  instruction[5:0]
//   alu_ctrl   out 3  ALUControl encoding; unknown Funct decodes to add
module mc_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared memory and
// one ALU for LW, SW, R-type, BEQ, ADDI and J, stalling on MemReady.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   Op, Funct            instruction fields from the instruction register
//   Zero                 ALU zero flag (gates PCEn in BRANCH)
//   MemReady             memory access complete this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUControl[2:0], PCSrc[1:0], PCEn   datapath controls
//   Exception            illegal-opcode trap (only with ILLEGAL_OP_TRAP_EN)
// Parameter MEM_HANDSHAKE: 1 = wait on MemReady, 0 = memory always ready.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal Op enters a sticky TRAP state;
// otherwise an illegal Op is a 2-cycle NOP.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       PCEn,
  output logic       Exception
`else
  output logic       PCEn
`endif
);

  state_e state_q, state_d;

  logic       mem_rdy;
  logic [1:0] alu_op;
  logic       alu_en;
  logic [2:0] alu_ctrl_dec;

  logic       iord_raw, memwrite_raw, irwrite_raw, regdst_raw, memtoreg_raw;
  logic       regwrite_raw, alusrca_raw, pc_write, branch;
  logic [1:0] alusrcb_raw, pcsrc_raw;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       exception_raw;
`endif

  always_comb begin
    mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;
  end

  mc_alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .funct    (Funct),
    .alu_ctrl (alu_ctrl_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    alu_op       = ALUOP_ADD;
    alu_en       = 1'b0;
    iord_raw     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst_raw   = 1'b0;
    memtoreg_raw = 1'b0;
    regwrite_raw = 1'b0;
    alusrca_raw  = 1'b0;
    alusrcb_raw  = SRCB_REG;
    pcsrc_raw    = PCSRC_ALU;
    pc_write     = 1'b0;
    branch       = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    exception_raw = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alusrcb_raw = SRCB_FOUR;
        alu_en      = 1'b1;
        irwrite_raw = mem_rdy;
        pc_write    = mem_rdy;
        state_d     = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb_raw = SRCB_IMM_SH;
        alu_en      = 1'b1;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca_raw = 1'b1;
        alusrcb_raw = SRCB_IMM;
        alu_en      = 1'b1;
        if (Op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (Op == OP_SW) begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord_raw = 1'b1;
        state_d  = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_raw = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord_raw     = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca_raw = 1'b1;
        alu_op      = ALUOP_FUNCT;
        alu_en      = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_raw   = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca_raw = 1'b1;
        alu_op      = ALUOP_SUB;
        alu_en      = 1'b1;
        pcsrc_raw   = PCSRC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_raw = 1'b1;
        alusrcb_raw = SRCB_IMM;
        alu_en      = 1'b1;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
      end
      S_JUMP: begin
        pcsrc_raw = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        exception_raw = 1'b1;
        state_d       = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // ALUControl is forced to 0 outside ALU-using states so that every
  // unlisted output reads 0; reset low blanks all outputs combinationally.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = '0;
    ALUControl = '0;
    PCSrc      = '0;
    PCEn       = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    Exception  = 1'b0;
`endif
    if (rst_n) begin
      IorD       = iord_raw;
      MemWrite   = memwrite_raw;
      IRWrite    = irwrite_raw;
      RegDst     = regdst_raw;
      MemToReg   = memtoreg_raw;
      RegWrite   = regwrite_raw;
      ALUSrcA    = alusrca_raw;
      ALUSrcB    = alusrcb_raw;
      ALUControl = alu_en ? alu_ctrl_dec : '0;
      PCSrc      = pcsrc_raw;
      PCEn       = pc_write | (branch & Zero);
`ifdef ILLEGAL_OP_TRAP_EN
      Exception  = exception_raw;
`endif
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller. The driver issues whole
// instructions and pushes a per-instruction summary predicted from the
// instruction-level rules; the monitor splits the output stream at each
// FETCH entry, summarizes what it saw, and compares against the queue.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       Exception;
`endif

  always #5 clk = ~clk;

  mc_controller #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc),
`ifdef ILLEGAL_OP_TRAP_EN
    .PCEn(PCEn),
    .Exception(Exception)
`else
    .PCEn(PCEn)
`endif
  );

  typedef struct packed {
    int cycles;
    int rw;
    int rdst;
    int m2r;
    int mw;
    int iord;
    int pcen;
    int pcsrc_x;
    int irw;
    int has_alu;
    int alu;
  } rec_t;

  rec_t sb_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  // Instruction-level reference: what one instruction should look like.
  function automatic rec_t predict(input logic [5:0] op, input logic [5:0] fn,
                                   input bit z, input int f, input int m);
    rec_t r;
    r = '0;
    r.irw = 1;
    r.pcen = 1;
    case (op)
      6'b100011: begin r.cycles = 5 + f + m; r.rw = 1; r.m2r = 1; r.iord = 1 + m;
                       r.has_alu = 1; r.alu = 2; end
      6'b101011: begin r.cycles = 4 + f + m; r.mw = 1 + m; r.iord = 1 + m;
                       r.has_alu = 1; r.alu = 2; end
      6'b000000: begin r.cycles = 4 + f; r.rw = 1; r.rdst = 1;
                       r.has_alu = 1; r.alu = funct_alu(fn); end
      6'b001000: begin r.cycles = 4 + f; r.rw = 1; r.has_alu = 1; r.alu = 2; end
      6'b000100: begin r.cycles = 3 + f; r.has_alu = 1; r.alu = 6;
                       if (z) begin r.pcen = 2; r.pcsrc_x = 1; end end
      6'b000010: begin r.cycles = 3 + f; r.pcen = 2; r.pcsrc_x = 2; end
      default:   r.cycles = 2 + f;
    endcase
    return r;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
  endfunction

  // Called at posedge+1 of the first FETCH cycle; returns likewise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input int f, input int m);
    rec_t r;
    bit is_mem;
    r = predict(op, fn, z, f, m);
    sb_q.push_back(r);
    is_mem = (op == 6'b100011) || (op == 6'b101011);
    Op = op;
    Funct = fn;
    for (int c = 0; c < r.cycles; c++) begin
      MemReady = 1'($urandom);
      Zero     = 1'($urandom);
      if (c < f) MemReady = 1'b0;
      else if (c == f) MemReady = 1'b1;
      if (is_mem && c >= f + 3) MemReady = (c == f + 3 + m);
      if (op == 6'b000100 && c == f + 2) Zero = z;
      @(posedge clk); #1;
    end
  endtask

  // Monitor
  rec_t cur;
  bit   open_r = 0;
  bit   prev_fetch = 0;
  int   n_chk = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ALUSrcB == 2'b01 && !prev_fetch) begin
        if (open_r) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_instr", 1, 0);
          end else begin
            rec_t e;
            e = sb_q.pop_front();
            chk($sformatf("i%0d cycles", n_chk), cur.cycles, e.cycles);
            chk($sformatf("i%0d regwrite", n_chk), cur.rw, e.rw);
            if (e.rw != 0) begin
              chk($sformatf("i%0d regdst", n_chk), cur.rdst, e.rdst);
              chk($sformatf("i%0d memtoreg", n_chk), cur.m2r, e.m2r);
            end
            chk($sformatf("i%0d memwrite", n_chk), cur.mw, e.mw);
            chk($sformatf("i%0d iord", n_chk), cur.iord, e.iord);
            chk($sformatf("i%0d pcen", n_chk), cur.pcen, e.pcen);
            chk($sformatf("i%0d pcsrc", n_chk), cur.pcsrc_x, e.pcsrc_x);
            chk($sformatf("i%0d irwrite", n_chk), cur.irw, e.irw);
            chk($sformatf("i%0d alu_used", n_chk), cur.has_alu, e.has_alu);
            if (e.has_alu != 0)
              chk($sformatf("i%0d aluctl", n_chk), cur.alu, e.alu);
            n_chk++;
          end
        end
        cur = '0;
        open_r = 1;
      end
      prev_fetch = (ALUSrcB == 2'b01);
      if (open_r) begin
        cur.cycles++;
        if (RegWrite) begin cur.rw++; cur.rdst = int'(RegDst); cur.m2r = int'(MemToReg); end
        if (MemWrite) cur.mw++;
        if (IorD) cur.iord++;
        if (PCEn) begin
          cur.pcen++;
          if (ALUSrcB != 2'b01) cur.pcsrc_x = int'(PCSrc);
        end
        if (IRWrite) cur.irw++;
        if (ALUSrcA && cur.has_alu == 0) begin cur.has_alu = 1; cur.alu = int'(ALUControl); end
      end
    end
  end

  function automatic logic [14:0] all_outs();
    return {IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, PCEn};
  endfunction

  initial begin
    logic [5:0] op, fn;
    int k, f, m;
    logic [5:0] legal_ops [6];
    logic [5:0] functs [6];
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b010101};

    rst_n = 1'b0; Op = '0; Funct = '0; Zero = 1'b1; MemReady = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_outputs_zero", int'(all_outs()), 0);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("reset_exception_zero", int'(Exception), 0);
`endif
    rst_n = 1'b1;
    MemReady = 1'b0;
    #1;
    chk("reset_state_fetch_srcb", int'(ALUSrcB), 1);
    chk("reset_state_fetch_alu", int'(ALUControl), 2);
    chk("fetch_stall_no_pcen", int'(PCEn | IRWrite), 0);

    mon_en = 1'b1;
    for (int i = 0; i < 160; i++) begin
      k = $urandom_range(0, 6);
`ifdef ILLEGAL_OP_TRAP_EN
      if (k == 6) k = 0;
`endif
      if (k < 6) begin
        op = legal_ops[k];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      fn = functs[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      m = $urandom_range(0, 3);
      run_instr(op, fn, 1'($urandom), f, m);
    end
    MemReady = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("instr_checked", n_chk, 160);

    // Reset asserted while stalled in MEMRD.
    Op = 6'b100011; MemReady = 1'b1;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("memrd_iord", int'(IorD), 1);
    rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b1;
    #1;
    chk("midstall_reset_outputs_zero", int'(all_outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; MemReady = 1'b0;
    #1;
    chk("post_reset_fetch_srcb", int'(ALUSrcB), 1);
    chk("post_reset_no_regwrite", int'(RegWrite | MemToReg), 0);
    MemReady = 1'b1;
    #1;
    chk("post_reset_fetch_pulse", int'({IRWrite, PCEn}), 3);

`ifdef ILLEGAL_OP_TRAP_EN
    Op = 6'b111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("trap_exception", int'(Exception), 1);
    chk("trap_outputs_zero", int'(all_outs()), 0);
    @(posedge clk); #1;
    chk("trap_sticky", int'(Exception), 1);
`else
    Op = 6'b111111;
    @(posedge clk); #1;
    chk("illegal_decode_srcb", int'(ALUSrcB), 3);
    @(posedge clk); #1;
    chk("illegal_back_to_fetch", int'(ALUSrcB), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
